// File: rtl/div_seq_pkg.sv
// Shared types for the sequential divider.
package div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/add_sub.sv
// Combinational adder/subtractor: z = x + y, or x - y when sign is set.
module add_sub #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sign,
  output logic [W-1:0] z
);

  always_comb begin
    z = sign ? (x - y) : (x + y);
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle,
// with valid/ready handshakes on operands and results.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(W);

  div_state_e    state;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  d_reg;
  logic [W:0]    r_reg;
  logic [CW-1:0] cnt;

  logic [W:0]    rs;
  logic [W+1:0]  sub_x;
  logic [W+1:0]  sub_y;
  logic [W+1:0]  sub_z;
  logic [W-1:0]  q_next;
  logic [W:0]    r_next;
  logic          unused_r_msb;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    rs    = {r_reg[W-1:0], q_reg[W-1]};
    sub_x = {1'b0, rs};
    sub_y = {2'b00, d_reg};
  end

  add_sub #(.W(W + 2)) u_add_sub (
    .x    (sub_x),
    .y    (sub_y),
    .sign (1'b1),
    .z    (sub_z)
  );

  // Borrow in the top bit means the divisor did not fit: restore.
  always_comb begin
    if (!sub_z[W+1]) begin
      r_next = sub_z[W:0];
      q_next = {q_reg[W-2:0], 1'b1};
    end else begin
      r_next = rs;
      q_next = {q_reg[W-2:0], 1'b0};
    end
  end

  // R < D keeps the partial remainder's top bit at zero.
  assign unused_r_msb = r_reg[W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              q_reg <= dividend;
              d_reg <= divisor;
              r_reg <= '0;
              cnt   <= CW'(W - 1);
            end
          end
        end
        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: W=8 vector table plus hand-written corner sequences,
// and one W=32 divide.
module tb_div_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  logic        in_valid32;
  logic        in_ready32;
  logic [31:0] dividend32;
  logic [31:0] divisor32;
  logic        out_valid32;
  logic        out_ready32;
  logic [31:0] quotient32;
  logic [31:0] remainder32;
  logic        div_by_zero32;

  int errors = 0;
  int checks = 0;

  div_seq #(.W(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  div_seq #(.W(32)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid32),
    .in_ready    (in_ready32),
    .dividend    (dividend32),
    .divisor     (divisor32),
    .out_valid   (out_valid32),
    .out_ready   (out_ready32),
    .quotient    (quotient32),
    .remainder   (remainder32),
    .div_by_zero (div_by_zero32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; returns after the accept edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid; optionally spray junk operands.
  task automatic wait_done(input bit junk, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (junk) begin
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        in_valid = 1'($urandom_range(0, 1));
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk("out_valid_reached", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;

    vecs[0] = '{a: 8'd100, b: 8'd7,  q: 8'd14,  r: 8'd2,  dbz: 1'b0, lat: 8};
    vecs[1] = '{a: 8'd5,   b: 8'd0,  q: 8'hFF,  r: 8'd5,  dbz: 1'b1, lat: 0};
    vecs[2] = '{a: 8'd255, b: 8'd1,  q: 8'd255, r: 8'd0,  dbz: 1'b0, lat: 8};
    vecs[3] = '{a: 8'd3,   b: 8'd10, q: 8'd0,   r: 8'd3,  dbz: 1'b0, lat: 8};
    vecs[4] = '{a: 8'd0,   b: 8'd5,  q: 8'd0,   r: 8'd0,  dbz: 1'b0, lat: 8};
    vecs[5] = '{a: 8'd250, b: 8'd16, q: 8'd15,  r: 8'd10, dbz: 1'b0, lat: 8};
    vecs[6] = '{a: 8'd255, b: 8'd255, q: 8'd1,  r: 8'd0,  dbz: 1'b0, lat: 8};

    rst         = 1'b1;
    in_valid    = 1'b0;
    dividend    = '0;
    divisor     = '0;
    out_ready   = 1'b0;
    in_valid32  = 1'b0;
    dividend32  = '0;
    divisor32   = '0;
    out_ready32 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);

    // Divide-by-zero lands in DONE on the accept edge itself, so its latency is 0 extra edges.
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(1'b0, lat);
      chk($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_in_ready_done", i), 32'(in_ready), 32'd0);
      handshake();
    end

    // Backpressure: result must hold while out_ready stays low.
    start_op(8'd200, 8'd9);
    wait_done(1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      chk("bp_quotient", 32'(quotient), 32'd22);
      chk("bp_remainder", 32'(remainder), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    handshake();

    // Junk operands during CALC must not disturb the running divide.
    start_op(8'd100, 8'd7);
    wait_done(1'b1, lat);
    chk("junk_quotient", 32'(quotient), 32'd14);
    chk("junk_remainder", 32'(remainder), 32'd2);
    chk("junk_latency", 32'(lat), 32'd8);
    handshake();

    // Reset during the 4th CALC cycle discards the operation.
    start_op(8'd100, 8'd7);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    start_op(8'd64, 8'd8);
    wait_done(1'b0, lat);
    chk("postrst_quotient", 32'(quotient), 32'd8);
    chk("postrst_remainder", 32'(remainder), 32'd0);
    chk("postrst_latency", 32'(lat), 32'd8);
    handshake();

    // W=32 divide.
    chk("w32_in_ready", 32'(in_ready32), 32'd1);
    in_valid32 = 1'b1;
    dividend32 = 32'hFFFF_FFFF;
    divisor32  = 32'h0001_0000;
    tick();
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 200) begin
      tick();
      lat++;
    end
    chk("w32_out_valid", 32'(out_valid32), 32'd1);
    chk("w32_quotient", quotient32, 32'h0000_FFFF);
    chk("w32_remainder", remainder32, 32'h0000_FFFF);
    chk("w32_dbz", 32'(div_by_zero32), 32'd0);
    chk("w32_latency", 32'(lat), 32'd32);
    out_ready32 = 1'b1;
    tick();
    out_ready32 = 1'b0;
    chk("w32_out_valid_after_hs", 32'(out_valid32), 32'd0);
    chk("w32_in_ready_after_hs", 32'(in_ready32), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
